// File: rtl/control_unit.sv
// Multi-cycle LEGv8 control FSM: IDLE/FETCH/EXEC/MEM/HALT sequencing, datapath control word and PC control.
// Optional B.cond decode is enabled by defining COND_BRANCH_EN.
module control_unit #(
    parameter logic [4:0] FS_ADD   = 5'b01000,
    parameter logic [4:0] FS_SUB   = 5'b01001,
    parameter logic [4:0] FS_AND   = 5'b00000,
    parameter logic [4:0] FS_ORR   = 5'b00100,
    parameter logic [4:0] FS_EOR   = 5'b01100,
    parameter logic [4:0] FS_PASSB = 5'b10100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic [31:0] i_instr,
    input  logic [4:0]  i_status,
    output logic [63:0] o_k,
    output logic [4:0]  o_reg_addr,
    output logic [4:0]  o_a_addr,
    output logic [4:0]  o_b_addr,
    output logic [4:0]  o_fs,
    output logic        o_c0,
    output logic        o_reg_w,
    output logic        o_b_sel,
    output logic        o_b_en,
    output logic        o_alu_en,
    output logic        o_mem_en,
    output logic        o_chip_sel,
    output logic        o_mem_w,
    output logic        o_mem_r,
    output logic        o_stat_en,
    output logic [1:0]  o_ps,
    output logic        o_pc_sel,
    output logic        o_ir_load,
    output logic        o_halted,
    output logic        o_illegal
);
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;

    logic [10:0] w_op11;
    logic [4:0]  w_rd, w_rn, w_rm;
    logic [63:0] w_k_imm12, w_k_dt9, w_k_br19, w_k_br26;
    logic        w_is_alu_r, w_is_alu_i, w_sub, w_setf, w_is_ldst, w_cb_taken, w_cond_taken;
    logic [4:0]  w_fs_alu;

    assign w_op11    = r_ir[31:21];
    assign w_rd      = r_ir[4:0];
    assign w_rn      = r_ir[9:5];
    assign w_rm      = r_ir[20:16];
    assign w_k_imm12 = {52'd0, r_ir[21:10]};
    assign w_k_dt9   = {{55{r_ir[20]}}, r_ir[20:12]};
    assign w_k_br19  = {{45{r_ir[23]}}, r_ir[23:5]};
    assign w_k_br26  = {{38{r_ir[25]}}, r_ir[25:0]};
    assign w_is_ldst = (w_op11 == OP_LDUR) || (w_op11 == OP_STUR);
    // CBZ branches on a live zero, CBNZ on a live non-zero
    assign w_cb_taken = i_status[0] ^ r_ir[24];

`ifdef COND_BRANCH_EN
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] vcnz);
        logic v, c, n, z;
        {v, c, n, z} = vcnz;
        case (cond)
            4'd0:    cond_met = z;
            4'd1:    cond_met = !z;
            4'd2:    cond_met = c;
            4'd3:    cond_met = !c;
            4'd4:    cond_met = n;
            4'd5:    cond_met = !n;
            4'd6:    cond_met = v;
            4'd7:    cond_met = !v;
            4'd8:    cond_met = c && !z;
            4'd9:    cond_met = !(c && !z);
            4'd10:   cond_met = (n == v);
            4'd11:   cond_met = (n != v);
            4'd12:   cond_met = !z && (n == v);
            4'd13:   cond_met = !(!z && (n == v));
            default: cond_met = 1'b1;
        endcase
    endfunction
    assign w_cond_taken = cond_met(r_ir[3:0], i_status[4:1]);
`else
    logic w_unused_flags;
    assign w_unused_flags = ^i_status[4:1];
    assign w_cond_taken   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ir    <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_ir <= i_instr;
            end
        end
    end

    // ALU-class decode: register or immediate form, subtract and flag-setting variants
    always_comb begin
        w_is_alu_r = 1'b0;
        w_is_alu_i = 1'b0;
        w_setf     = 1'b0;
        w_sub      = 1'b0;
        w_fs_alu   = FS_ADD;
        case (w_op11)
            OP_ADD:  w_is_alu_r = 1'b1;
            OP_ADDS: begin w_is_alu_r = 1'b1; w_setf = 1'b1; end
            OP_SUB:  begin w_is_alu_r = 1'b1; w_sub = 1'b1; end
            OP_SUBS: begin w_is_alu_r = 1'b1; w_sub = 1'b1; w_setf = 1'b1; end
            OP_AND:  begin w_is_alu_r = 1'b1; w_fs_alu = FS_AND; end
            OP_ORR:  begin w_is_alu_r = 1'b1; w_fs_alu = FS_ORR; end
            OP_EOR:  begin w_is_alu_r = 1'b1; w_fs_alu = FS_EOR; end
            default: begin
                w_is_alu_i = (r_ir[31:22] == OP_ADDI) || (r_ir[31:22] == OP_SUBI);
                w_sub      = (r_ir[31:22] == OP_SUBI);
            end
        endcase
        if (w_sub) begin
            w_fs_alu = FS_SUB;
        end else begin
            w_fs_alu = w_fs_alu;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_k        = 64'd0;
        o_reg_addr = 5'd0;
        o_a_addr   = 5'd0;
        o_b_addr   = 5'd0;
        o_fs       = 5'd0;
        o_c0       = 1'b0;
        o_reg_w    = 1'b0;
        o_b_sel    = 1'b0;
        o_b_en     = 1'b0;
        o_alu_en   = 1'b0;
        o_mem_en   = 1'b0;
        o_chip_sel = 1'b0;
        o_mem_w    = 1'b0;
        o_mem_r    = 1'b0;
        o_stat_en  = 1'b0;
        o_ps       = 2'b00;
        o_pc_sel   = 1'b0;
        o_ir_load  = 1'b0;
        o_halted   = 1'b0;
        o_illegal  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) w_next = S_FETCH;
                else       w_next = S_IDLE;
            end
            S_FETCH: begin
                o_ir_load = 1'b1;
                if (i_run) w_next = S_EXEC;
                else       w_next = S_IDLE;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                o_ps   = 2'b01;
                if (r_ir == 32'h0000_0000) begin
                    o_ps   = 2'b00;
                    w_next = S_HALT;
                end else if (w_is_alu_r || w_is_alu_i) begin
                    o_a_addr   = w_rn;
                    o_reg_addr = w_rd;
                    o_reg_w    = 1'b1;
                    o_alu_en   = 1'b1;
                    o_fs       = w_fs_alu;
                    o_c0       = w_sub;
                    o_stat_en  = w_setf;
                    if (w_is_alu_i) begin
                        o_b_sel = 1'b1;
                        o_k     = w_k_imm12;
                    end else begin
                        o_b_addr = w_rm;
                    end
                end else if (w_is_ldst) begin
                    o_a_addr = w_rn;
                    o_b_sel  = 1'b1;
                    o_k      = w_k_dt9;
                    o_fs     = FS_ADD;
                    o_mem_en = 1'b1;
                    o_ps     = 2'b00;
                    w_next   = S_MEM;
                end else if (r_ir[31:26] == OP_B) begin
                    o_k      = w_k_br26;
                    o_ps     = 2'b11;
                    o_pc_sel = 1'b1;
                end else if ((r_ir[31:24] == OP_CBZ) || (r_ir[31:24] == OP_CBNZ)) begin
                    o_b_addr = w_rd;
                    o_fs     = FS_PASSB;
                    if (w_cb_taken) begin
                        o_k      = w_k_br19;
                        o_ps     = 2'b11;
                        o_pc_sel = 1'b1;
                    end else begin
                        o_ps = 2'b01;
                    end
`ifdef COND_BRANCH_EN
                end else if (r_ir[31:24] == OP_BCOND) begin
                    if (w_cond_taken) begin
                        o_k      = w_k_br19;
                        o_ps     = 2'b11;
                        o_pc_sel = 1'b1;
                    end else begin
                        o_ps = 2'b01;
                    end
`endif
                end else begin
                    o_illegal = 1'b1;
                end
            end
            S_MEM: begin
                w_next   = S_FETCH;
                o_ps     = 2'b01;
                o_a_addr = w_rn;
                o_b_sel  = 1'b1;
                o_k      = w_k_dt9;
                o_fs     = FS_ADD;
                o_mem_en = 1'b1;
                if (w_op11 == OP_LDUR) begin
                    o_mem_r    = 1'b1;
                    o_chip_sel = 1'b1;
                    o_reg_w    = 1'b1;
                    o_reg_addr = w_rd;
                end else begin
                    o_b_addr = w_rd;
                    o_b_en   = 1'b1;
                    o_mem_w  = 1'b1;
                end
            end
            S_HALT: begin
                o_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model predicts every cycle's control word.
module tb_control_unit;
    localparam logic [4:0] FS_ADD = 5'b01000, FS_SUB = 5'b01001, FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100, FS_EOR = 5'b01100, FS_PASSB = 5'b10100;

    typedef struct packed {
        logic [63:0] k;
        logic [4:0]  reg_addr, a_addr, b_addr, fs;
        logic        c0, reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en;
        logic [1:0]  ps;
        logic        pc_sel, ir_load, halted, illegal;
    } out_t;

    logic        clk, rst, run;
    logic [31:0] instr;
    logic [4:0]  status;
    logic [63:0] o_k;
    logic [4:0]  o_reg_addr, o_a_addr, o_b_addr, o_fs;
    logic        o_c0, o_reg_w, o_b_sel, o_b_en, o_alu_en, o_mem_en, o_chip_sel, o_mem_w, o_mem_r, o_stat_en;
    logic [1:0]  o_ps;
    logic        o_pc_sel, o_ir_load, o_halted, o_illegal;
    out_t        act;

    int n_tests = 0;
    int n_fail  = 0;
    out_t  exp_q[$];
    string name_q[$];

    control_unit dut (
        .clk(clk), .rst(rst), .i_run(run), .i_instr(instr), .i_status(status),
        .o_k(o_k), .o_reg_addr(o_reg_addr), .o_a_addr(o_a_addr), .o_b_addr(o_b_addr),
        .o_fs(o_fs), .o_c0(o_c0), .o_reg_w(o_reg_w), .o_b_sel(o_b_sel), .o_b_en(o_b_en),
        .o_alu_en(o_alu_en), .o_mem_en(o_mem_en), .o_chip_sel(o_chip_sel), .o_mem_w(o_mem_w),
        .o_mem_r(o_mem_r), .o_stat_en(o_stat_en), .o_ps(o_ps), .o_pc_sel(o_pc_sel),
        .o_ir_load(o_ir_load), .o_halted(o_halted), .o_illegal(o_illegal)
    );

    assign act = {o_k, o_reg_addr, o_a_addr, o_b_addr, o_fs, o_c0, o_reg_w, o_b_sel, o_b_en,
                  o_alu_en, o_mem_en, o_chip_sel, o_mem_w, o_mem_r, o_stat_en, o_ps, o_pc_sel,
                  o_ir_load, o_halted, o_illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic cond_ok(input logic [3:0] cd, input logic [4:0] st);
        logic v, c, n, z, base;
        {v, c, n, z} = st[4:1];
        case (cd[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: return 1'b1;
        endcase
        return cd[0] ? !base : base;
    endfunction

    function automatic out_t zero_m();
        out_t e;
        e = '0;
        return e;
    endfunction

    function automatic out_t fetch_m();
        out_t e;
        e = '0;
        e.ir_load = 1'b1;
        return e;
    endfunction

    function automatic out_t halt_m();
        out_t e;
        e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    // Instruction semantics grouped by ISA encoding families
    function automatic out_t exec_m(input logic [31:0] ins, input logic [4:0] st);
        out_t e;
        e = '0;
        e.ps = 2'b01;
        if (ins == 32'h0) begin
            e.ps = 2'b00;
        end else if (ins[31] && ins[28:21] == 8'b01011000) begin
            e.a_addr = ins[9:5]; e.b_addr = ins[20:16]; e.reg_addr = ins[4:0];
            e.reg_w = 1'b1; e.alu_en = 1'b1;
            e.fs = ins[30] ? FS_SUB : FS_ADD; e.c0 = ins[30]; e.stat_en = ins[29];
        end else if (ins[31] && ins[28:21] == 8'b01010000 && ins[30:29] != 2'b11) begin
            e.a_addr = ins[9:5]; e.b_addr = ins[20:16]; e.reg_addr = ins[4:0];
            e.reg_w = 1'b1; e.alu_en = 1'b1;
            e.fs = (ins[30:29] == 2'b00) ? FS_AND : (ins[30:29] == 2'b01) ? FS_ORR : FS_EOR;
        end else if (ins[31] && ins[29:22] == 8'b01000100) begin
            e.a_addr = ins[9:5]; e.reg_addr = ins[4:0]; e.reg_w = 1'b1; e.alu_en = 1'b1;
            e.b_sel = 1'b1; e.k = {52'd0, ins[21:10]};
            e.fs = ins[30] ? FS_SUB : FS_ADD; e.c0 = ins[30];
        end else if (ins[31:23] == 9'b111110000 && !ins[21]) begin
            e.a_addr = ins[9:5]; e.b_sel = 1'b1; e.k = 64'($signed(ins[20:12]));
            e.fs = FS_ADD; e.mem_en = 1'b1; e.ps = 2'b00;
        end else if (ins[31:26] == 6'b000101) begin
            e.k = 64'($signed(ins[25:0])); e.ps = 2'b11; e.pc_sel = 1'b1;
        end else if (ins[31:25] == 7'b1011010) begin
            e.b_addr = ins[4:0]; e.fs = FS_PASSB;
            if (st[0] != ins[24]) begin
                e.k = 64'($signed(ins[23:5])); e.ps = 2'b11; e.pc_sel = 1'b1;
            end
`ifdef COND_BRANCH_EN
        end else if (ins[31:24] == 8'b01010100) begin
            if (cond_ok(ins[3:0], st)) begin
                e.k = 64'($signed(ins[23:5])); e.ps = 2'b11; e.pc_sel = 1'b1;
            end
`endif
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic out_t mem_m(input logic [31:0] ins);
        out_t e;
        e = '0;
        e.a_addr = ins[9:5]; e.b_sel = 1'b1; e.k = 64'($signed(ins[20:12]));
        e.fs = FS_ADD; e.mem_en = 1'b1; e.ps = 2'b01;
        if (ins[22]) begin
            e.mem_r = 1'b1; e.chip_sel = 1'b1; e.reg_w = 1'b1; e.reg_addr = ins[4:0];
        end else begin
            e.b_addr = ins[4:0]; e.b_en = 1'b1; e.mem_w = 1'b1;
        end
        return e;
    endfunction

    // Per-cycle comparison of the whole control word against the model
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                out_t e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    task automatic push(input out_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic t_step();
        @(posedge clk);
        #1;
    endtask

    task automatic t_fetch(input logic [31:0] ins);
        instr = ins;
        push(fetch_m(), "fetch");
        t_step();
    endtask

    task automatic t_exec(input logic [31:0] ins, input logic [4:0] st, input string nm);
        status = st;
        instr  = $urandom;
        push(exec_m(ins, st), nm);
        #1;
    endtask

    task automatic t_simple(input logic [31:0] ins, input logic [4:0] st, input string nm);
        t_fetch(ins);
        t_exec(ins, st, nm);
        t_step();
    endtask

    localparam logic [31:0] I_ADD  = 32'h8B02_0023;
    localparam logic [31:0] I_SUB  = 32'hCB0B_0149;
    localparam logic [31:0] I_EOR  = 32'hCA03_0041;
    localparam logic [31:0] I_ADDI = 32'h913F_FD07;
    localparam logic [31:0] I_SUBS = 32'hEB03_0041;
    localparam logic [31:0] I_BEQ  = 32'h5400_00A0;
    localparam logic [31:0] I_LDUR = 32'hF85F_8045;
    localparam logic [31:0] I_STUR = 32'hF801_0026;
    localparam logic [31:0] I_CBZ  = 32'hB400_0064;
    localparam logic [31:0] I_CBNZ = 32'hB500_0064;
    localparam logic [31:0] I_B    = 32'h17FF_FFFE;
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

    initial begin
        rst = 1'b1; run = 1'b0; instr = 32'h0; status = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        push(zero_m(), "reset");
        chk("reset_word", {36'd0, act[99:36]}, 64'd0);
        chk("reset_ctrl", 64'(act[35:0]), 64'd0);
        t_step();
        rst = 1'b0; run = 1'b1;
        push(zero_m(), "idle");
        t_step();

        // ADD X3,X1,X2
        t_fetch(I_ADD);
        t_exec(I_ADD, 5'd0, "add_exec");
        chk("add_a", o_a_addr, 64'd1);
        chk("add_b", o_b_addr, 64'd2);
        chk("add_rd", o_reg_addr, 64'd3);
        chk("add_ctl", {o_reg_w, o_alu_en, o_fs, o_c0, o_ps}, {55'd0, 1'b1, 1'b1, FS_ADD, 1'b0, 2'b01});
        t_step();
        t_simple(I_SUB, 5'd0, "sub_exec");
        t_simple(I_EOR, 5'd0, "eor_exec");
        t_fetch(I_ADDI);
        t_exec(I_ADDI, 5'd0, "addi_exec");
        chk("addi_k", o_k, 64'h0000_0000_0000_0FFF);
        t_step();
        t_simple(I_SUBS, 5'd0, "subs_exec");

        t_fetch(I_BEQ);
        t_exec(I_BEQ, 5'b00010, "beq_exec");
`ifdef COND_BRANCH_EN
        chk("beq_ps", o_ps, 64'd3);
`else
        chk("beq_illegal", {o_illegal, o_ps}, 64'b101);
`endif
        t_step();

        // LDUR X5,[X2,#-8]
        t_fetch(I_LDUR);
        t_exec(I_LDUR, 5'd0, "ldur_exec");
        chk("ldur_k", o_k, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur_exec_ctl", {o_mem_en, o_ps}, 64'b100);
        t_step();
        push(mem_m(I_LDUR), "ldur_mem");
        #1;
        chk("ldur_mem_ctl", {o_mem_r, o_chip_sel, o_reg_w, o_reg_addr}, {56'd0, 3'b111, 5'd5});
        t_step();

        t_fetch(I_CBZ);
        t_exec(I_CBZ, 5'b00001, "cbz_taken");
        chk("cbz_taken", {o_ps, o_k}, {2'b11, 64'd3});
        t_step();
        t_fetch(I_CBZ);
        t_exec(I_CBZ, 5'b00000, "cbz_not_taken");
        chk("cbz_nt_ps", o_ps, 64'd1);
        t_step();
        t_simple(I_CBNZ, 5'b00000, "cbnz_taken");
        t_simple(I_CBNZ, 5'b00001, "cbnz_not_taken");

        t_fetch(I_B);
        t_exec(I_B, 5'd0, "b_exec");
        chk("b_k", o_k, 64'hFFFF_FFFF_FFFF_FFFE);
        t_step();

        t_fetch(I_BAD);
        t_exec(I_BAD, 5'd0, "bad_exec");
        chk("bad_illegal", o_illegal, 64'd1);
        t_step();

        // run dropped during FETCH returns to IDLE
        run = 1'b0;
        t_fetch(I_ADD);
        push(zero_m(), "idle_after_fetch");
        t_step();
        run = 1'b1;
        push(zero_m(), "idle_rerun");
        t_step();

        // STUR X6,[X1,#16] with reset during MEM
        t_fetch(I_STUR);
        t_exec(I_STUR, 5'd0, "stur_exec");
        t_step();
        #1;
        chk("stur_mem_w", {o_mem_w, o_b_en, o_b_addr}, {57'd0, 2'b11, 5'd6});
        push(zero_m(), "stur_rst");
        rst = 1'b1;
        #1;
        chk("stur_rst_mem_w", o_mem_w, 64'd0);
        t_step();
        rst = 1'b0;
        push(zero_m(), "idle_after_rst");
        t_step();

        // Zero instruction halts until reset
        t_fetch(32'h0);
        t_exec(32'h0, 5'd0, "halt_exec");
        t_step();
        for (int i = 0; i < 3; i++) begin
            instr = $urandom;
            push(halt_m(), "halted");
            t_step();
        end
        chk("halted_lit", o_halted, 64'd1);
        rst = 1'b1;
        push(zero_m(), "halt_rst");
        t_step();
        rst = 1'b0; run = 1'b0;
        push(zero_m(), "idle_final");
        t_step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
